// File: rtl/entity_compositor_pkg.sv
// Shared entity field layout, sprite geometry and orientation encodings.
// Imported by the compositor, its interface and the sprite ROM.
package entity_compositor_pkg;

  localparam int ENT_W   = 14;
  localparam int ID_W    = 4;
  localparam int ID_LSB  = 10;
  localparam int ORI_W   = 2;
  localparam int ORI_LSB = 8;
  localparam int ROW_W   = 4;
  localparam int ROW_LSB = 4;
  localparam int COL_W   = 4;
  localparam int COL_LSB = 0;

  localparam logic [ID_W-1:0]  ID_UNUSED = 4'hF;
  localparam logic [ENT_W-1:0] ENT_RESET = {ID_UNUSED, 10'd0};

  localparam int SPRITE_SIZE = 8;
  localparam int SPRITE_BITS = 3;

  localparam logic [ORI_W-1:0] ORI_NONE      = 2'b00;
  localparam logic [ORI_W-1:0] ORI_MIRROR_X  = 2'b01;
  localparam logic [ORI_W-1:0] ORI_MIRROR_Y  = 2'b10;
  localparam logic [ORI_W-1:0] ORI_MIRROR_XY = 2'b11;

endpackage

// File: rtl/entity_compositor_if.sv
// Entity write channel plus pixel request/response bundle of the compositor.
// master = frame/scan controller, slave = compositor.
interface entity_compositor_if;
  import entity_compositor_pkg::*;

  logic              wr_valid;
  logic              wr_ready;
  logic [3:0]        wr_index;
  logic [ENT_W-1:0]  wr_entity;
  logic              frame_start;
  logic [9:0]        counter_h;
  logic [9:0]        counter_v;
  logic              pixel_valid_in;
  logic              colour;
  logic              colour_valid;
  logic [ID_W-1:0]   hit_id;

  modport master (
    output wr_valid, wr_index, wr_entity, frame_start,
           counter_h, counter_v, pixel_valid_in,
    input  wr_ready, colour, colour_valid, hit_id
  );

  modport slave (
    input  wr_valid, wr_index, wr_entity, frame_start,
           counter_h, counter_v, pixel_valid_in,
    output wr_ready, colour, colour_valid, hit_id
  );
endinterface

// File: rtl/entity_compositor_sprite_rom.sv
// Sixteen 8x8 one-bit sprites indexed by id; bit {y,x} of each 64-bit word.
// Combinational read; id F is blank.
module entity_sprite_rom
  import entity_compositor_pkg::*;
(
  input  logic [ID_W-1:0]        id,
  input  logic [SPRITE_BITS-1:0] x,
  input  logic [SPRITE_BITS-1:0] y,
  output logic                   pixel
);

  logic [SPRITE_SIZE*SPRITE_SIZE-1:0] sprite;

  // Byte n of each word is sprite row n, bit x within the byte is column x.
  always_comb begin
    case (id)
      4'd0:    sprite = 64'hFF81_8181_8181_81FF;
      4'd1:    sprite = 64'h0101_0101_0101_0101;
      4'd2:    sprite = 64'h8040_2010_0804_0201;
      4'd3:    sprite = 64'h0F0F_0F0F_0F0F_0F0F;
      4'd4:    sprite = 64'hAA55_AA55_AA55_AA55;
      4'd5:    sprite = 64'h00FF_00FF_00FF_00FF;
      4'd6:    sprite = 64'h183C_7EFF_FF7E_3C18;
      4'd7:    sprite = 64'hF0F0_F0F0_F0F0_F0F0;
      4'd8:    sprite = 64'h0102_0408_1020_4080;
      4'd9:    sprite = 64'h3C42_8181_8181_423C;
      4'd10:   sprite = 64'hFFFF_FFFF_0000_0000;
      4'd11:   sprite = 64'h0000_0000_FFFF_FFFF;
      4'd12:   sprite = 64'h5555_5555_5555_5555;
      4'd13:   sprite = 64'hCCCC_3333_CCCC_3333;
      4'd14:   sprite = 64'h1122_4488_1122_4488;
      default: sprite = '0;
    endcase
  end

  assign pixel = sprite[{y, x}];

endmodule

// File: rtl/entity_compositor.sv
// Tile-based entity compositor with shadow/active entity banks; ENTITY_FLIP_EN enables mirroring.
// Latency 2 cycles, one pixel per cycle.
// Writes stall (wr_ready=0) during reset and on frame_start cycles; pixel path never stalls.
module entity_compositor
  import entity_compositor_pkg::*;
#(
  parameter int NUM_ENTITIES = 9,
  parameter int SCALE_SHIFT  = 2
) (
  input  logic               clk,
  input  logic               reset,
  entity_compositor_if.slave bus
);

  localparam int TILE_SHIFT = SPRITE_BITS + SCALE_SHIFT;

  logic [ENT_W-1:0] shadow_bank [NUM_ENTITIES];
  logic [ENT_W-1:0] active_bank [NUM_ENTITIES];

  logic wr_fire;

  assign bus.wr_ready = !reset && !bus.frame_start;
  assign wr_fire      = bus.wr_valid && bus.wr_ready;

  // Out-of-range indices are accepted but match no channel, so they vanish.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_ENTITIES; i++) begin
        shadow_bank[i] <= ENT_RESET;
        active_bank[i] <= ENT_RESET;
      end
    end else begin
      for (int i = 0; i < NUM_ENTITIES; i++) begin
        if (wr_fire && bus.wr_index == 4'(i))
          shadow_bank[i] <= bus.wr_entity;
        if (bus.frame_start)
          active_bank[i] <= shadow_bank[i];
      end
    end
  end

  logic [9:0]             tile_h_full;
  logic [9:0]             tile_v_full;
  logic                   in_range;
  logic [COL_W-1:0]       tile_col;
  logic [ROW_W-1:0]       tile_row;
  logic [SPRITE_BITS-1:0] px_x;
  logic [SPRITE_BITS-1:0] px_y;

  assign tile_h_full = bus.counter_h >> TILE_SHIFT;
  assign tile_v_full = bus.counter_v >> TILE_SHIFT;
  assign in_range    = (tile_h_full < 10'd16) && (tile_v_full < 10'd16);
  assign tile_col    = tile_h_full[COL_W-1:0];
  assign tile_row    = tile_v_full[ROW_W-1:0];
  assign px_x        = bus.counter_h[SCALE_SHIFT +: SPRITE_BITS];
  assign px_y        = bus.counter_v[SCALE_SHIFT +: SPRITE_BITS];

  logic            win_hit;
  logic [ID_W-1:0] win_id;
`ifdef ENTITY_FLIP_EN
  logic [ORI_W-1:0] win_ori;
`endif

  // Scan from the top channel down so the lowest matching index is written last and wins.
  always_comb begin
    win_hit = 1'b0;
    win_id  = ID_UNUSED;
`ifdef ENTITY_FLIP_EN
    win_ori = ORI_NONE;
`endif
    for (int i = NUM_ENTITIES - 1; i >= 0; i--) begin
      if (in_range &&
          active_bank[i][ID_LSB +: ID_W] != ID_UNUSED &&
          active_bank[i][ROW_LSB +: ROW_W] == tile_row &&
          active_bank[i][COL_LSB +: COL_W] == tile_col) begin
        win_hit = 1'b1;
        win_id  = active_bank[i][ID_LSB +: ID_W];
`ifdef ENTITY_FLIP_EN
        win_ori = active_bank[i][ORI_LSB +: ORI_W];
`endif
      end
    end
  end

  logic [SPRITE_BITS-1:0] spr_x;
  logic [SPRITE_BITS-1:0] spr_y;

`ifdef ENTITY_FLIP_EN
  assign spr_x = ((win_ori & ORI_MIRROR_X) != '0) ? ~px_x : px_x;
  assign spr_y = ((win_ori & ORI_MIRROR_Y) != '0) ? ~px_y : px_y;
`else
  assign spr_x = px_x;
  assign spr_y = px_y;
`endif

  logic                   s1_vld;
  logic                   s1_hit;
  logic [ID_W-1:0]        s1_id;
  logic [SPRITE_BITS-1:0] s1_x;
  logic [SPRITE_BITS-1:0] s1_y;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld <= 1'b0;
      s1_hit <= 1'b0;
      s1_id  <= ID_UNUSED;
      s1_x   <= '0;
      s1_y   <= '0;
    end else begin
      s1_vld <= bus.pixel_valid_in;
      s1_hit <= win_hit;
      s1_id  <= win_id;
      s1_x   <= spr_x;
      s1_y   <= spr_y;
    end
  end

  logic rom_pixel;

  entity_sprite_rom u_rom (
    .id    (s1_id),
    .x     (s1_x),
    .y     (s1_y),
    .pixel (rom_pixel)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.colour       <= 1'b0;
      bus.colour_valid <= 1'b0;
      bus.hit_id       <= ID_UNUSED;
    end else begin
      bus.colour       <= s1_hit & rom_pixel;
      bus.colour_valid <= s1_vld;
      bus.hit_id       <= s1_id;
    end
  end

endmodule

// File: tb/tb_entity_compositor.sv
// Directed bench for entity_compositor: hand-computed pixels plus a small scoreboard for scans.
module tb_entity_compositor;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  entity_compositor_if bus ();

  entity_compositor #(
    .NUM_ENTITIES (9),
    .SCALE_SHIFT  (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected shadow/active contents, channels 0..8 meaningful.
  logic [13:0] sh_m [16];
  logic [13:0] ac_m [16];

  function automatic logic [63:0] sprite_of(input logic [3:0] id);
    case (id)
      4'd0:    return 64'hFF818181818181FF;
      4'd1:    return 64'h0101010101010101;
      4'd2:    return 64'h8040201008040201;
      4'd3:    return 64'h0F0F0F0F0F0F0F0F;
      4'd7:    return 64'hF0F0F0F0F0F0F0F0;
      default: return 64'h0;
    endcase
  endfunction

  // 32-pixel tiles, 4-pixel sprite texels.
  task automatic model(input int h, input int v, output logic c, output logic [3:0] id);
    int tc, tr, x, y, xx, yy;
    logic [63:0] spr;
    tc = h / 32; tr = v / 32; x = (h / 4) % 8; y = (v / 4) % 8;
    c = 1'b0; id = 4'hF;
    if (tc < 16 && tr < 16) begin
      for (int i = 0; i < 9; i++) begin
        if (ac_m[i][13:10] != 4'hF && int'(ac_m[i][7:4]) == tr && int'(ac_m[i][3:0]) == tc) begin
          xx = x; yy = y;
`ifdef ENTITY_FLIP_EN
          if (ac_m[i][8]) xx = 7 - x;
          if (ac_m[i][9]) yy = 7 - y;
`endif
          id  = ac_m[i][13:10];
          spr = sprite_of(id);
          c   = spr[yy * 8 + xx];
          break;
        end
      end
    end
  endtask

  typedef struct packed { logic vld; logic c; logic [3:0] id; } exp_t;
  exp_t pend[$];

  // One pixel per call on consecutive cycles; checks the pixel issued two calls earlier.
  task automatic px(input int h, input int v, input logic vld, input logic fs);
    exp_t e, o;
    @(negedge clk);
    if (pend.size() == 2) begin
      o = pend.pop_front();
      check_val("scan.colour_valid", bus.colour_valid, o.vld);
      if (o.vld) begin
        check_val("scan.colour", bus.colour, o.c);
        check_val("scan.hit_id", bus.hit_id, o.id);
      end
    end
    bus.counter_h      = 10'(h);
    bus.counter_v      = 10'(v);
    bus.pixel_valid_in = vld;
    bus.frame_start    = fs;
    e.vld = vld;
    model(h, v, e.c, e.id);
    pend.push_back(e);
    if (fs) for (int i = 0; i < 16; i++) ac_m[i] = sh_m[i];
  endtask

  task automatic drain();
    px(0, 0, 1'b0, 1'b0);
    px(0, 0, 1'b0, 1'b0);
  endtask

  task automatic sweep(input int h0, input int h1, input int hs, input int v0, input int v1, input int vs);
    for (int v = v0; v <= v1; v += vs)
      for (int h = h0; h <= h1; h += hs)
        px(h, v, 1'b1, 1'b0);
    drain();
  endtask

  task automatic wr(input int idx, input logic [13:0] ent, input logic fs);
    @(negedge clk);
    bus.wr_valid    = 1'b1;
    bus.wr_index    = 4'(idx);
    bus.wr_entity   = ent;
    bus.frame_start = fs;
    #1;
    check_val("wr_ready", bus.wr_ready, !fs);
    if (!fs && idx < 9) sh_m[idx] = ent;
    if (fs) for (int i = 0; i < 16; i++) ac_m[i] = sh_m[i];
    @(negedge clk);
    bus.wr_valid    = 1'b0;
    bus.frame_start = 1'b0;
  endtask

  task automatic frame();
    @(negedge clk);
    bus.frame_start = 1'b1;
    #1;
    check_val("frame.wr_ready", bus.wr_ready, 0);
    for (int i = 0; i < 16; i++) ac_m[i] = sh_m[i];
    @(negedge clk);
    bus.frame_start = 1'b0;
  endtask

  // Single isolated pixel against hand-computed values.
  task automatic dpx(input string tag, input int h, input int v, input logic ec, input logic [3:0] eid);
    @(negedge clk);
    bus.counter_h      = 10'(h);
    bus.counter_v      = 10'(v);
    bus.pixel_valid_in = 1'b1;
    @(negedge clk);
    bus.pixel_valid_in = 1'b0;
    @(negedge clk);
    check_val({tag, ".colour_valid"}, bus.colour_valid, 1);
    check_val({tag, ".colour"}, bus.colour, ec);
    check_val({tag, ".hit_id"}, bus.hit_id, eid);
  endtask

  logic flip_c;

  initial begin
    reset              = 1'b1;
    bus.wr_valid       = 1'b0;
    bus.wr_index       = 4'd0;
    bus.wr_entity      = 14'd0;
    bus.frame_start    = 1'b0;
    bus.counter_h      = 10'd0;
    bus.counter_v      = 10'd0;
    bus.pixel_valid_in = 1'b0;
    for (int i = 0; i < 16; i++) begin sh_m[i] = 14'h3C00; ac_m[i] = 14'h3C00; end

    repeat (3) @(negedge clk);
    check_val("rst.colour", bus.colour, 0);
    check_val("rst.colour_valid", bus.colour_valid, 0);
    check_val("rst.hit_id", bus.hit_id, 4'hF);
    check_val("rst.wr_ready", bus.wr_ready, 0);
    reset = 1'b0;
    #1;
    check_val("idle.wr_ready", bus.wr_ready, 1);

    // Empty banks: background everywhere, colour_valid exactly two cycles after first valid.
    drain();
    frame();
    sweep(0, 639, 8, 0, 479, 16);

    // Single box sprite at tile (1,1).
    wr(0, 14'h0011, 1'b0);
    frame();
    dpx("t1.corner", 32, 32, 1'b1, 4'h0);
    dpx("t1.inner", 44, 44, 1'b0, 4'h0);
    dpx("t1.right_edge", 63, 40, 1'b1, 4'h0);
    dpx("t1.past_right", 64, 40, 1'b0, 4'hF);
    dpx("t1.before_left", 31, 40, 1'b0, 4'hF);
    drain();
    sweep(0, 639, 8, 0, 479, 16);
    sweep(24, 71, 1, 24, 71, 4);

    // Overlap at tile (2,2): channel 2 (ID3) beats channel 5 (ID7).
    wr(2, 14'h0C22, 1'b0);
    wr(5, 14'h1C22, 1'b0);
    frame();
    dpx("t2.prio_x0", 64, 64, 1'b1, 4'h3);
    dpx("t2.prio_x7", 92, 64, 1'b0, 4'h3);
    drain();
    sweep(56, 103, 2, 56, 103, 4);

    // Mirror-x sprite at tile (0,0); out-of-range tiles must not alias onto it.
    wr(1, 14'h0500, 1'b0);
    frame();
`ifdef ENTITY_FLIP_EN
    flip_c = 1'b0;
`else
    flip_c = 1'b1;
`endif
    dpx("t3.orient", 0, 0, flip_c, 4'h1);
    dpx("t3.col16", 512, 0, 1'b0, 4'hF);
    dpx("t3.row16", 0, 512, 1'b0, 4'hF);

    // Write during frame_start is refused; out-of-range index is swallowed.
    wr(1, 14'h3C00, 1'b1);
    frame();
    dpx("t4.kept", 0, 0, flip_c, 4'h1);
    wr(12, 14'h0833, 1'b0);
    frame();
    dpx("t4.idx12", 96, 96, 1'b0, 4'hF);
    dpx("t4.ch0", 32, 32, 1'b1, 4'h0);

    // Swap while pixels are streaming: pixels sampled at the swap edge still see the old bank.
    wr(0, 14'h0811, 1'b0);
    drain();
    px(40, 40, 1'b1, 1'b0);
    px(40, 40, 1'b1, 1'b0);
    px(40, 40, 1'b1, 1'b1);
    px(40, 40, 1'b1, 1'b0);
    px(40, 40, 1'b1, 1'b0);
    drain();
    dpx("t5.new", 40, 40, 1'b1, 4'h2);

    // Reset mid-scan with a write and frame_start pending in the same cycle.
    px(40, 40, 1'b1, 1'b0);
    px(40, 40, 1'b1, 1'b0);
    @(negedge clk);
    reset           = 1'b1;
    bus.frame_start = 1'b1;
    bus.wr_valid    = 1'b1;
    bus.wr_index    = 4'd0;
    bus.wr_entity   = 14'h0011;
    #1;
    check_val("t6.wr_ready", bus.wr_ready, 0);
    @(negedge clk);
    check_val("t6.colour", bus.colour, 0);
    check_val("t6.colour_valid", bus.colour_valid, 0);
    check_val("t6.hit_id", bus.hit_id, 4'hF);
    reset              = 1'b0;
    bus.frame_start    = 1'b0;
    bus.wr_valid       = 1'b0;
    bus.pixel_valid_in = 1'b0;
    pend.delete();
    for (int i = 0; i < 16; i++) begin sh_m[i] = 14'h3C00; ac_m[i] = 14'h3C00; end
    frame();
    dpx("t6.after_a", 40, 40, 1'b0, 4'hF);
    dpx("t6.after_b", 0, 0, 1'b0, 4'hF);
    dpx("t6.after_c", 64, 64, 1'b0, 4'hF);
    drain();
    sweep(0, 639, 16, 0, 479, 32);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
